// File: rtl/scan_pkg.sv
// Shared definitions for the display digit-scan path: default sizing,
// the IDX width helper and the generic index-to-one-hot function.
package scan_pkg;

    localparam int DEF_DIGITS = 4;
    localparam int DEF_DIV    = 100000;

    // Widest select bus the shared one-hot function can produce.
    localparam int MAX_DIGITS = 32;

    // Width of an index covering 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // n-bit one-hot of idx, returned in a MAX_DIGITS-wide vector.
    // An index outside 0..n-1 yields all zeros.
    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx,
                                                     input int unsigned n);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        if (idx < n && idx < MAX_DIGITS)
            v[idx[4:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational index-to-select decoder, one-hot or one-cold.
// Out-of-range indices decode to all-inactive. Shared by the timer display paths.
module onehot_decoder
    import scan_pkg::*;
#(
    parameter int N          = DEF_DIGITS,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [idx_width(N)-1:0] idx,
    output logic [N-1:0]            sel
);

    if (N < 2 || N > MAX_DIGITS) begin : g_bad_n
        $error("onehot_decoder: N must be in 2..%0d", MAX_DIGITS);
    end

    logic [MAX_DIGITS-1:0] hot;

    // Decode the index, then apply the select polarity.
    always_comb begin
        hot = onehot(32'(idx), N);
        sel = ACTIVE_LOW ? ~hot[N-1:0] : hot[N-1:0];
    end

endmodule

// File: rtl/digit_scan_1hot.sv
// Free-running multiplexed 7-segment digit scanner.
// Divides CLK into DIV-cycle slots and steps a registered digit select over DIGITS digits.
// Optional feature macro: BLANK_GAP_EN blanks OUT for the first GAP cycles of every slot.
module digit_scan_1hot
    import scan_pkg::*;
#(
    parameter int DIGITS     = DEF_DIGITS,
    parameter int DIV        = DEF_DIV,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int GAP        = 0
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         EN,
    output logic [idx_width(DIGITS)-1:0] IDX,
    output logic [DIGITS-1:0]            OUT,
    output logic                         TICK
);

    localparam int IW = idx_width(DIGITS);
    localparam int PW = idx_width(DIV);

    localparam logic [PW-1:0]     PRE_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] INACTIVE = {DIGITS{ACTIVE_LOW}};

    if (DIGITS < 2) begin : g_bad_digits
        $error("digit_scan_1hot: DIGITS must be >= 2");
    end
    if (DIV < 2) begin : g_bad_div
        $error("digit_scan_1hot: DIV must be >= 2");
    end
    if (GAP < 0 || GAP >= DIV) begin : g_bad_gap
        $error("digit_scan_1hot: GAP must be in 0..DIV-1");
    end

    logic [PW-1:0]     pre;
    logic [DIGITS-1:0] dec_sel;
    logic              blank;

    onehot_decoder #(
        .N          (DIGITS),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_decoder (
        .idx (IDX),
        .sel (dec_sel)
    );

`ifdef BLANK_GAP_EN
    if (GAP > 0) begin : g_gap
        // Blank the leading GAP cycles of each slot to suppress ghosting.
        assign blank = (pre < PW'(GAP));
    end else begin : g_no_gap
        assign blank = 1'b0;
    end
`else
    assign blank = 1'b0;
`endif

    // Prescaler, digit index and registered select/tick outputs.
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values;
    // the reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pre  <= '0;
            IDX  <= '0;
            TICK <= 1'b0;
            OUT  <= INACTIVE;
        end else if (EN) begin
            OUT  <= blank ? INACTIVE : dec_sel;
            TICK <= (pre == PRE_LAST);
            if (pre == PRE_LAST) begin
                pre <= '0;
                IDX <= (IDX == IDX_LAST) ? '0 : IDX + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
        end else begin
            TICK <= 1'b0;
            OUT  <= INACTIVE;
        end
    end

endmodule
